// File: rtl/quadrature_generator.sv
// Quadrature encoder emulator: a phase accumulator driven by a signed rate
// advances an A/B Gray-code state, a signed position count and an index pulse.
module quadrature_generator #(
  parameter int ACC_WIDTH = 16,
  parameter int CPR       = 400
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               en,
  input  logic [9:0]         rate,
  output logic               outa,
  output logic               outb,
  output logic               step,
  output logic               dir,
  output logic signed [15:0] position,
  output logic               index
);

  localparam int REV_W = (CPR > 2) ? $clog2(CPR) : 1;
  localparam logic [REV_W-1:0] REV_MAX = REV_W'(CPR - 1);

  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q10 = 2'b10,
    Q11 = 2'b11,
    Q01 = 2'b01
  } quad_t;

  quad_t                   quad;
  quad_t                   quad_next;
  logic [ACC_WIDTH-1:0]    acc;
  logic [ACC_WIDTH:0]      sum;
  logic [9:0]              mag;
  logic                    carry;
  logic                    forward;
  logic                    advance;
  logic [REV_W-1:0]        rev;
  logic [REV_W-1:0]        rev_next;
  logic                    rev_wrap;
  logic signed [15:0]      position_next;

  // Magnitude of -512 is 512, which still fits in ten unsigned bits.
  assign mag     = rate[9] ? (~rate + 10'd1) : rate;
  assign forward = ~rate[9];
  assign sum     = {1'b0, acc} + {{(ACC_WIDTH + 1 - 10){1'b0}}, mag};
  assign carry   = sum[ACC_WIDTH];
  assign advance = en & carry;

  assign outa = quad[1];
  assign outb = quad[0];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      quad <= Q00;
    end else begin
      quad <= quad_next;
    end
  end

  // The direction is taken on the step edge itself, so a reversal simply
  // walks one state back from wherever the sequence currently sits.
  always_comb begin
    quad_next = quad;
    if (advance) begin
      unique case (quad)
        Q00: quad_next = forward ? Q10 : Q01;
        Q10: quad_next = forward ? Q11 : Q00;
        Q11: quad_next = forward ? Q01 : Q10;
        Q01: quad_next = forward ? Q00 : Q11;
        default: quad_next = Q00;
      endcase
    end
  end

  always_comb begin
    rev_next = rev;
    rev_wrap = 1'b0;
    if (forward) begin
      rev_wrap = (rev == REV_MAX);
      rev_next = rev_wrap ? '0 : rev + REV_W'(1);
    end else begin
      rev_wrap = (rev == '0);
      rev_next = rev_wrap ? REV_MAX : rev - REV_W'(1);
    end
    position_next = forward ? position + 16'sd1 : position - 16'sd1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      acc      <= '0;
      rev      <= '0;
      position <= '0;
      step     <= 1'b0;
      index    <= 1'b0;
      dir      <= 1'b1;
    end else if (!en) begin
      acc   <= '0;
      step  <= 1'b0;
      index <= 1'b0;
    end else begin
      acc   <= sum[ACC_WIDTH-1:0];
      step  <= carry;
      index <= carry & rev_wrap;
      if (carry) begin
        position <= position_next;
        rev      <= rev_next;
        dir      <= forward;
      end
    end
  end

endmodule

// File: tb/tb_quadrature_generator.sv
// Directed bench for quadrature_generator: stepping timing, A/B sequence,
// reversal, index, enable/zero rate, async reset and position wrap.
module tb_quadrature_generator;

  logic               clk;
  logic               arst_n;
  logic               en;
  logic [9:0]         rate;
  logic               outa;
  logic               outb;
  logic               step;
  logic               dir;
  logic signed [15:0] position;
  logic               index;

  logic               w_en;
  logic [9:0]         w_rate;
  logic               w_outa;
  logic               w_outb;
  logic               w_step;
  logic               w_dir;
  logic signed [15:0] w_position;
  logic               w_index;

  int checks = 0;
  int failures = 0;
  int cycles;
  int pulses;

  quadrature_generator #(.ACC_WIDTH(16), .CPR(4)) u_dut (
    .clk(clk), .arst_n(arst_n), .en(en), .rate(rate),
    .outa(outa), .outb(outb), .step(step), .dir(dir),
    .position(position), .index(index)
  );

  quadrature_generator #(.ACC_WIDTH(10), .CPR(400)) u_wrap (
    .clk(clk), .arst_n(arst_n), .en(w_en), .rate(w_rate),
    .outa(w_outa), .outb(w_outb), .step(w_step), .dir(w_dir),
    .position(w_position), .index(w_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Counts falling edges until the main DUT shows a step pulse, bounded by budget.
  task automatic waitStep(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step && n < budget);
    checkOutput("step_seen", {31'b0, step}, 32'd1);
  endtask

  task automatic checkStep(input string tag, input int n, input int exp_n, input logic [1:0] exp_ab,
                           input logic [15:0] exp_pos, input logic exp_idx, input logic exp_dir);
    checkOutput({tag, "_cycles"}, n, exp_n);
    checkOutput({tag, "_ab"}, {30'b0, outa, outb}, {30'b0, exp_ab});
    checkOutput({tag, "_pos"}, {16'b0, position}, {16'b0, exp_pos});
    checkOutput({tag, "_index"}, {31'b0, index}, {31'b0, exp_idx});
    checkOutput({tag, "_dir"}, {31'b0, dir}, {31'b0, exp_dir});
  endtask

  logic [1:0]  fwd_ab [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0]  rev_ab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [15:0] rev_pos[4] = '{16'd4, 16'd3, 16'd2, 16'd1};
  logic        rev_idx[4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    arst_n = 1'b0;
    en     = 1'b0;
    rate   = 10'd0;
    w_en   = 1'b0;
    w_rate = 10'd0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ab", {30'b0, outa, outb}, 32'd0);
    checkOutput("rst_pos", {16'b0, position}, 32'd0);
    checkOutput("rst_step", {31'b0, step}, 32'd0);
    checkOutput("rst_index", {31'b0, index}, 32'd0);
    checkOutput("rst_dir", {31'b0, dir}, 32'd1);

    // Forward at +256: one step per 256 clocks, index on the 4th step.
    arst_n = 1'b1;
    en     = 1'b1;
    rate   = 10'h100;
    for (int i = 0; i < 4; i++) begin
      waitStep(400, cycles);
      checkStep($sformatf("fwd%0d", i + 1), cycles, 256, fwd_ab[i], 16'(i + 1), (i == 3), 1'b1);
    end
    @(negedge clk);
    checkOutput("step_falls", {31'b0, step}, 32'd0);
    checkOutput("index_falls", {31'b0, index}, 32'd0);

    // Disable mid-accumulation; re-enabling must need a full 256 clocks.
    repeat (99) @(negedge clk);
    en = 1'b0;
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (step) pulses++;
    end
    checkOutput("en0_steps", pulses, 0);
    checkOutput("en0_ab", {30'b0, outa, outb}, 32'd0);
    checkOutput("en0_pos", {16'b0, position}, 32'd4);
    en = 1'b1;
    waitStep(400, cycles);
    checkStep("reen", cycles, 256, 2'b10, 16'd5, 1'b0, 1'b1);

    // Zero rate holds everything.
    rate = 10'd0;
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (step) pulses++;
    end
    checkOutput("zero_steps", pulses, 0);
    checkOutput("zero_ab", {30'b0, outa, outb}, 32'h2);

    // Reversal mid-accumulation keeps the accumulated phase.
    rate = 10'h100;
    waitStep(400, cycles);
    checkStep("pre_rev", cycles, 256, 2'b11, 16'd6, 1'b0, 1'b1);
    repeat (100) @(negedge clk);
    rate = 10'h300;
    waitStep(400, cycles);
    checkStep("rev_switch", cycles, 156, 2'b10, 16'd5, 1'b0, 1'b0);

    // Reverse at -512; rev is at 0 before the second step, so it wraps there.
    rate = 10'h200;
    for (int i = 0; i < 4; i++) begin
      waitStep(200, cycles);
      checkStep($sformatf("rev%0d", i + 1), cycles, 128, rev_ab[i], rev_pos[i], rev_idx[i], 1'b0);
    end

    // Asynchronous reset asserted between clock edges.
    repeat (60) @(negedge clk);
    @(posedge clk);
    #3 arst_n = 1'b0;
    #1;
    checkOutput("arst_ab", {30'b0, outa, outb}, 32'd0);
    checkOutput("arst_pos", {16'b0, position}, 32'd0);
    checkOutput("arst_step", {31'b0, step}, 32'd0);
    checkOutput("arst_index", {31'b0, index}, 32'd0);
    checkOutput("arst_dir", {31'b0, dir}, 32'd1);
    @(negedge clk);
    @(posedge clk);
    #1 checkOutput("arst_hold_pos", {16'b0, position}, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    rate   = 10'h100;
    waitStep(400, cycles);
    checkStep("post_rst", cycles, 256, 2'b10, 16'd1, 1'b0, 1'b1);

    // Position wrap on the narrow-accumulator instance: -512 steps every 2 clocks.
    w_en   = 1'b1;
    w_rate = 10'h200;
    repeat (65536) @(negedge clk);
    checkOutput("wrap_neg_pos", {16'b0, w_position}, 32'h8000);
    checkOutput("wrap_neg_ab", {30'b0, w_outa, w_outb}, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("wrap_under_pos", {16'b0, w_position}, 32'h7FFF);
    checkOutput("wrap_under_dir", {31'b0, w_dir}, 32'd0);
    w_rate = 10'h1FF;
    repeat (3) @(negedge clk);
    checkOutput("wrap_over_step", {31'b0, w_step}, 32'd1);
    checkOutput("wrap_over_pos", {16'b0, w_position}, 32'h8000);
    checkOutput("wrap_over_dir", {31'b0, w_dir}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
